// File: rtl/ctrl_ckt_pkg.sv
// Purpose: shared constants and types for the ctrl_ckt control decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ctrl_ckt_pkg;

   typedef logic [1:0] sel_t;

   // Select codes naming the winning request line.
   localparam sel_t SEL_X0 = 2'b00;
   localparam sel_t SEL_X1 = 2'b01;
   localparam sel_t SEL_X2 = 2'b10;
   localparam sel_t SEL_X3 = 2'b11;

   // Legal stability-filter depths. The 4-bit counter saturates at the
   // depth, so 15 is the largest depth it can represent.
   localparam int FILTER_DEPTH_MIN = 1;
   localparam int FILTER_DEPTH_MAX = 15;
   localparam int CNT_W            = 4;

endpackage : ctrl_ckt_pkg

// File: rtl/ctrl_ckt_prio_enc.sv
// Purpose: combinational 4->2 priority encoder with an all-zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_req   [3:0]  request vector
//   o_sel   [1:0]  index of the winning request (00 when no request)
//   o_zero         1 when i_req is all-zero
//
// PRIORITY_HIGH=1: highest set index wins. PRIORITY_HIGH=0: lowest wins.
module ctrl_ckt_prio_enc
   import ctrl_ckt_pkg::*;
#(
   parameter int PRIORITY_HIGH = 1
) (
   input  logic [3:0] i_req,
   output sel_t       o_sel,
   output logic       o_zero
);

   sel_t w_sel;

   generate
      if (PRIORITY_HIGH != 0) begin : g_high
         always_comb begin
            w_sel = SEL_X0;
            if (i_req[3])      w_sel = SEL_X3;
            else if (i_req[2]) w_sel = SEL_X2;
            else if (i_req[1]) w_sel = SEL_X1;
            else               w_sel = SEL_X0;
         end
      end else begin : g_low
         always_comb begin
            w_sel = SEL_X0;
            if (i_req[0])      w_sel = SEL_X0;
            else if (i_req[1]) w_sel = SEL_X1;
            else if (i_req[2]) w_sel = SEL_X2;
            else if (i_req[3]) w_sel = SEL_X3;
            else               w_sel = SEL_X0;
         end
      end
   endgenerate

   assign o_sel  = w_sel;
   assign o_zero = (i_req == 4'b0000);

endmodule : ctrl_ckt_prio_enc

// File: rtl/ctrl_ckt.sv
// Purpose: registered request decoder with optional input stability filter.
// Latency: FILTER_DEPTH clocks from a stable x to updated outputs (1 when unfiltered).
// Backpressure: none; x is sampled every clock, unaccepted patterns are dropped.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous reset, active-high
//   x      [3:0] request vector
//   s0     select code LSB (registered)
//   s1     select code MSB (registered)
//   reset  downstream clear (registered), 1 when accepted vector is zero
module ctrl_ckt
   import ctrl_ckt_pkg::*;
#(
   parameter int FILTER_DEPTH  = 1,
   parameter int PRIORITY_HIGH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] x,
   output logic       s0,
   output logic       s1,
   output logic       reset
);

   generate
      if (FILTER_DEPTH < FILTER_DEPTH_MIN || FILTER_DEPTH > FILTER_DEPTH_MAX) begin : g_bad_depth
         $fatal(1, "ctrl_ckt: FILTER_DEPTH=%0d outside %0d..%0d",
                FILTER_DEPTH, FILTER_DEPTH_MIN, FILTER_DEPTH_MAX);
      end
   endgenerate

   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FILTER_DEPTH);

   logic [3:0]       r_cand;
   logic [CNT_W-1:0] r_cnt;
   sel_t             r_sel;
   logic             r_reset;

   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_accept;
   sel_t             w_sel;
   logic             w_zero;

   ctrl_ckt_prio_enc #(
      .PRIORITY_HIGH (PRIORITY_HIGH)
   ) u_prio_enc (
      .i_req  (x),
      .o_sel  (w_sel),
      .o_zero (w_zero)
   );

   // Saturating run-length of identical samples. The saturation test comes
   // before the increment so the counter never wraps.
   always_comb begin
      w_cnt_nxt = 4'd1;
      if (x == r_cand) begin
         if (r_cnt >= DEPTH) w_cnt_nxt = DEPTH;
         else                w_cnt_nxt = r_cnt + 4'd1;
      end
   end

   // Accepting on every saturated edge just reloads the same decode while x
   // is held, so outputs stay visually constant.
   assign w_accept = (w_cnt_nxt == DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cand  <= 4'b0000;
         r_cnt   <= '0;
         r_sel   <= SEL_X0;
         r_reset <= 1'b1;
      end else begin
         r_cand <= x;
         r_cnt  <= w_cnt_nxt;
         if (w_accept) begin
            r_sel   <= w_sel;
            r_reset <= w_zero;
         end
      end
   end

   assign s1    = r_sel[1];
   assign s0    = r_sel[0];
   assign reset = r_reset;

endmodule : ctrl_ckt

// File: tb/tb_ctrl_ckt.sv
// Purpose: directed self-checking bench for ctrl_ckt (three parameter sets).
// Latency: n/a.
// Backpressure: n/a.
module tb_ctrl_ckt;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] x   = 4'b1111;

   logic h_s0, h_s1, h_reset;   // FILTER_DEPTH=1, PRIORITY_HIGH=1
   logic l_s0, l_s1, l_reset;   // FILTER_DEPTH=1, PRIORITY_HIGH=0
   logic f_s0, f_s1, f_reset;   // FILTER_DEPTH=3, PRIORITY_HIGH=1

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_ckt #(.FILTER_DEPTH(1), .PRIORITY_HIGH(1)) u_dut_h (
      .clk (clk), .rst (rst), .x (x), .s0 (h_s0), .s1 (h_s1), .reset (h_reset)
   );
   ctrl_ckt #(.FILTER_DEPTH(1), .PRIORITY_HIGH(0)) u_dut_l (
      .clk (clk), .rst (rst), .x (x), .s0 (l_s0), .s1 (l_s1), .reset (l_reset)
   );
   ctrl_ckt #(.FILTER_DEPTH(3), .PRIORITY_HIGH(1)) u_dut_f (
      .clk (clk), .rst (rst), .x (x), .s0 (f_s0), .s1 (f_s1), .reset (f_reset)
   );

   // Hand-computed decode tables indexed by x.
   logic [1:0] exp_hi [16] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
   logic [1:0] exp_lo [16] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                               2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

   // Compares {s1,s0,reset}.
   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got {s1,s0,reset}=%b expected %b", tag, got, exp);
      end
   endtask

   // Apply x, let one rising edge sample it, then settle before checking.
   task automatic step(input logic [3:0] v);
      x = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held 3 cycles with x=1111.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(4'b1111);
         chk($sformatf("rst_h_%0d", i), {h_s1, h_s0, h_reset}, 3'b001);
         chk($sformatf("rst_f_%0d", i), {f_s1, f_s0, f_reset}, 3'b001);
      end
      rst = 1'b0;
      step(4'b1111);
      chk("rel_h", {h_s1, h_s0, h_reset}, 3'b110);
      chk("rel_l", {l_s1, l_s0, l_reset}, 3'b000);
      chk("rel_f_1", {f_s1, f_s0, f_reset}, 3'b001);
      step(4'b1111);
      chk("rel_f_2", {f_s1, f_s0, f_reset}, 3'b001);
      step(4'b1111);
      chk("rel_f_3", {f_s1, f_s0, f_reset}, 3'b110);

      // Full sweep on both unfiltered instances.
      for (int v = 0; v < 16; v++) begin
         step(4'(v));
         chk($sformatf("sweep_h_%0d", v), {h_s1, h_s0, h_reset}, {exp_hi[v], (v == 0)});
         chk($sformatf("sweep_l_%0d", v), {l_s1, l_s0, l_reset}, {exp_lo[v], (v == 0)});
      end

      // Glitch filter, depth 3: start clean.
      rst = 1'b1;
      step(4'b0000);
      rst = 1'b0;
      step(4'b0001);
      step(4'b0001);
      chk("flt_pre_acc", {f_s1, f_s0, f_reset}, 3'b001);
      step(4'b0001);
      chk("flt_acc_0001", {f_s1, f_s0, f_reset}, 3'b000);
      step(4'b1000);
      chk("flt_pulse_1", {f_s1, f_s0, f_reset}, 3'b000);
      step(4'b1000);
      chk("flt_pulse_2", {f_s1, f_s0, f_reset}, 3'b000);
      step(4'b0001);
      chk("flt_return", {f_s1, f_s0, f_reset}, 3'b000);
      step(4'b1000);
      chk("flt_hold_1", {f_s1, f_s0, f_reset}, 3'b000);
      step(4'b1000);
      chk("flt_hold_2", {f_s1, f_s0, f_reset}, 3'b000);
      step(4'b1000);
      chk("flt_hold_3", {f_s1, f_s0, f_reset}, 3'b110);
      step(4'b1000);
      chk("flt_hold_4", {f_s1, f_s0, f_reset}, 3'b110);

      // Reset mid-filter, depth 3.
      step(4'b0100);
      step(4'b0100);
      chk("mid_pre_rst", {f_s1, f_s0, f_reset}, 3'b110);
      rst = 1'b1;
      step(4'b0100);
      chk("mid_rst", {f_s1, f_s0, f_reset}, 3'b001);
      rst = 1'b0;
      step(4'b0100);
      chk("mid_post_1", {f_s1, f_s0, f_reset}, 3'b001);
      step(4'b0100);
      chk("mid_post_2", {f_s1, f_s0, f_reset}, 3'b001);
      step(4'b0100);
      chk("mid_post_3", {f_s1, f_s0, f_reset}, 3'b100);
      chk("mid_post_h", {h_s1, h_s0, h_reset}, 3'b100);
      chk("mid_post_l", {l_s1, l_s0, l_reset}, 3'b100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ctrl_ckt

// File: doc/ctrl_ckt.md
Name: ctrl_ckt

Overview:
- Registered control decoder. Takes a 4-bit request vector `x` and produces a 2-bit select code `{s1,s0}` naming the winning request line.
- Asserts a `reset` output while no request is active.
- Sits between request/status sources and a downstream 4:1 mux/counter datapath, which it steers via `s1`/`s0` and clears via `reset`.
- An optional stability filter suppresses outputs from glitching on short-lived input patterns.

Parameters:
- FILTER_DEPTH, default 1: consecutive identical clock samples of `x` required before the outputs update. Legal range 1..15. A value of 1 means no filtering.
- PRIORITY_HIGH, default 1: 1 means `x[3]` has the highest priority; 0 means `x[0]` has the highest priority.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- x  input  4  request vector, sampled on every rising `clk` edge.
- s0  output  1  select code LSB, registered.
- s1  output  1  select code MSB, registered.
- reset  output  1  downstream clear, registered; 1 when the accepted vector is all-zero.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - While `rst`=1 at an edge: `s1`=0, `s0`=0, `reset`=1, candidate register=0, stability count=0.
- Filter state:
  - Candidate register `cand[3:0]` and saturating counter `cnt` (4 bits).
  - Each edge with `rst`=0: if `x`==`cand`, then `cnt` <= min(`cnt`+1, FILTER_DEPTH). Otherwise `cand` <= `x` and `cnt` <= 1.
- Acceptance:
  - A sample is accepted on the edge where the new `cnt` value equals FILTER_DEPTH.
  - On that edge, the outputs load the decode of the sample taken at that edge.
  - With FILTER_DEPTH=1, every edge accepts: outputs equal decode(`x`) one cycle later, giving a latency of 1 clock.
  - Held stable input: the outputs keep reloading the same value, so there is no visible change.
  - Input that changes before reaching FILTER_DEPTH samples: the outputs hold their previous values.
- Decode, PRIORITY_HIGH=1 (winner is the highest set index):
  - `x[3]`=1 -> 11.
  - else `x[2]` -> 10.
  - else `x[1]` -> 01.
  - else `x[0]` -> 00.
- Decode, PRIORITY_HIGH=0 (winner is the lowest set index):
  - `x[0]` -> 00.
  - else `x[1]` -> 01.
  - else `x[2]` -> 10.
  - else `x[3]` -> 11.
- Zero vector: `x`==0000 -> {`s1`,`s0`}=00 and `reset`=1. For any nonzero accepted vector, `reset`=0.
- Collisions and timing:
  - Multiple set bits are resolved purely by priority; no error flag is produced.
  - Outputs never change combinationally with `x`.
  - `rst` asserted mid-filter discards the partial count. After release, the filter restarts from `cand`=0, `cnt`=0.
- Out-of-range parameters: FILTER_DEPTH outside 1..15 is rejected at elaboration with a fatal error.

Decomposition:
- Package ctrl_ckt_pkg holds:
  - Select code constants: SEL_X0=2'b00, SEL_X1=2'b01, SEL_X2=2'b10, SEL_X3=2'b11.
  - A 2-bit sel_t typedef.
  - FILTER_DEPTH bounds.
- One sub-module: ctrl_ckt_prio_enc, a combinational 4->2 priority encoder plus zero flag, parameterised by PRIORITY_HIGH.
- The filter, counter and output registers stay in ctrl_ckt.

Test Plan:
- Reset check: hold `rst`=1 for 3 cycles with `x`=1111 -> `s1`=0, `s0`=0, `reset`=1 throughout. Release with `x`=1111 -> next edge gives {`s1`,`s0`}=11, `reset`=0.
- Full sweep (FILTER_DEPTH=1, PRIORITY_HIGH=1): apply `x`=0000..1111, one value per cycle. Each response is checked one cycle later:
  - 0000 -> 00 with `reset`=1.
  - 0001 -> 00.
  - 0010, 0011 -> 01.
  - 0100..0111 -> 10.
  - 1000..1111 -> 11.
  - `reset`=0 for every nonzero value.
- Same sweep with PRIORITY_HIGH=0:
  - 0001, 0011, 0101 ... (`x[0]` set) -> 00.
  - 0010, 0110, 1010, 1110 -> 01.
  - 0100, 1100 -> 10.
  - 1000 -> 11.
  - 0000 -> 00 with `reset`=1.
- Glitch filter (FILTER_DEPTH=3): after acceptance of 0001, pulse `x`=1000 for 2 cycles, then return to 0001 -> outputs stay 00/`reset`=0. Then hold 1000 for 3 cycles -> {`s1`,`s0`}=11 exactly at the 3rd sampling edge.
- Reset mid-filter (FILTER_DEPTH=3): drive `x`=0100 for 2 cycles, assert `rst` 1 cycle, keep `x`=0100 -> outputs 00/`reset`=1 until 3 post-reset samples are taken, then 10/`reset`=0.
